// File: rtl/prbs26_checker.sv
// Serial checker for the x^26+x^8+x^7+x+1 PRBS stream: hunts, self-synchronises,
// then free-runs a local reference while LOCKED and counts bit errors.
module prbs26_checker #(
    parameter int unsigned LOCK_CNT  = 32,
    parameter int unsigned LOSS_ERRS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        din,
    input  logic        clr,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt
);

    localparam int unsigned WIN_LEN = 26;
    localparam int unsigned FILL_W  = 5;
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W   = 7;
    localparam int unsigned WCNT_W  = 6;
    localparam int unsigned ECNT_W  = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIN_LEN-1:0]   win_q, win_d;      // win_q[0] is the newest bit
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [MATCH_W-1:0]   match_inc;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic [BAD_W-1:0]     bad_base;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [ECNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;
    logic                 pred;
    logic                 bit_err;

    // Recurrence s[n+26] = s[n+8]^s[n+7]^s[n+1]^s[n] over the window taps.
    assign pred      = win_q[17] ^ win_q[18] ^ win_q[24] ^ win_q[25];
    assign match_inc = match_q + MATCH_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        fill_d    = fill_q;
        match_d   = match_q;
        bad_d     = bad_q;
        wcnt_d    = wcnt_q;
        err_cnt_d = err_cnt_q;
        bad_base  = bad_q;
        bit_err   = 1'b0;

        if (en) begin
            case (state_q)
                HUNT: begin
                    win_d = {win_q[WIN_LEN-2:0], din};
                    if (fill_q == FILL_W'(WIN_LEN - 1)) begin
                        state_d = SYNC;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end

                SYNC: begin
                    win_d = {win_q[WIN_LEN-2:0], din};
                    // An all-zero window trivially predicts zero, so it never counts.
                    if ((din == pred) && (win_q != '0)) begin
                        if (match_inc == MATCH_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            bad_d   = '0;
                            wcnt_d  = '0;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                LOCKED: begin
                    // Free-running reference: a line error never enters the window.
                    win_d    = {win_q[WIN_LEN-2:0], pred};
                    bit_err  = din ^ pred;
                    wcnt_d   = wcnt_q + WCNT_W'(1);
                    bad_base = (wcnt_q == '1) ? '0 : bad_q;
                    bad_d    = bad_base + BAD_W'(bit_err);
                    if (bad_d == BAD_W'(LOSS_ERRS)) begin
                        state_d = HUNT;
                        win_d   = '0;
                        fill_d  = '0;
                        match_d = '0;
                        bad_d   = '0;
                        wcnt_d  = '0;
                    end
                end

                default: begin
                    state_d = HUNT;
                    win_d   = '0;
                    fill_d  = '0;
                    match_d = '0;
                    bad_d   = '0;
                    wcnt_d  = '0;
                end
            endcase
        end

        if (clr) begin
            err_cnt_d = ECNT_W'(bit_err);
        end else if (bit_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ECNT_W'(1);
        end

        err_d    = bit_err;
        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            win_q     <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            bad_q     <= '0;
            wcnt_q    <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            bad_q     <= bad_d;
            wcnt_q    <= wcnt_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs26_checker.sv
// Randomised scoreboard bench for prbs26_checker: a queue-based reference model
// predicts locked/err/err_cnt per clock; a monitor compares them against the DUT.
module tb_prbs26_checker;

    localparam int LOCK_CNT  = 32;
    localparam int LOSS_ERRS = 8;
    localparam int WLEN      = 26;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        din   = 1'b0;
    logic        clr   = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        bit locked;
        bit err;
        int err_cnt;
    } exp_t;
    exp_t exp_q[$];

    // Stream generator: plain recurrence over a queue of the last 26 bits.
    bit gen[$];

    // Reference model state.
    bit m_hist[$];
    int m_state;        // 0 hunt, 1 sync, 2 locked
    int m_fill, m_match, m_pos, m_bad, m_errcnt;
    bit m_err;

    // Directed observation helpers.
    int vcount, lock_at, err_seen;
    bit ever_locked;

    prbs26_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_ERRS(LOSS_ERRS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .din     (din),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic gen_seed(input logic [25:0] s);
        gen.delete();
        for (int i = 0; i < WLEN; i++) gen.push_back(s[i]);
    endtask

    task automatic gen_next(output bit b);
        b = gen[0];
        gen.push_back(gen[8] ^ gen[7] ^ gen[1] ^ gen[0]);
        void'(gen.pop_front());
    endtask

    task automatic m_reset();
        m_hist.delete();
        m_state  = 0;
        m_fill   = 0;
        m_match  = 0;
        m_pos    = 0;
        m_bad    = 0;
        m_errcnt = 0;
        m_err    = 1'b0;
    endtask

    function automatic bit m_pred();
        int n = m_hist.size();
        return m_hist[n-18] ^ m_hist[n-19] ^ m_hist[n-25] ^ m_hist[n-26];
    endfunction

    function automatic bit m_nonzero();
        for (int i = 0; i < m_hist.size(); i++) if (m_hist[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit e, input bit d, input bit c);
        bit be = 1'b0;
        bit p;
        bit nz;
        if (e) begin
            if (m_state == 0) begin
                m_hist.push_back(d);
                m_fill++;
                if (m_fill == WLEN) begin
                    m_state = 1;
                    m_fill  = 0;
                    m_match = 0;
                end
            end else if (m_state == 1) begin
                p  = m_pred();
                nz = m_nonzero();
                m_hist.push_back(d);
                if (d == p && nz) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_state = 2;
                        m_pos   = 0;
                        m_bad   = 0;
                    end
                end else begin
                    m_match = 0;
                end
            end else begin
                p  = m_pred();
                be = d ^ p;
                m_hist.push_back(p);
                // Window boundary falls on the bit where the 6-bit count wraps.
                if (m_pos % 64 == 63) m_bad = 0;
                m_bad += int'(be);
                m_pos++;
                if (m_bad == LOSS_ERRS) begin
                    m_state = 0;
                    m_fill  = 0;
                    m_match = 0;
                    m_hist.delete();
                end
            end
            while (m_hist.size() > WLEN) void'(m_hist.pop_front());
        end
        if (c) m_errcnt = int'(be);
        else if (be && m_errcnt < 65535) m_errcnt++;
        m_err = be;
    endtask

    task automatic obs_clear();
        vcount      = 0;
        lock_at     = -1;
        err_seen    = 0;
        ever_locked = 1'b0;
    endtask

    // One clock of stimulus; expected post-edge outputs go to the scoreboard.
    task automatic cycle(input bit e, input bit d, input bit c);
        exp_t x;
        @(negedge clk);
        if (locked && lock_at < 0) lock_at = vcount;
        if (locked) ever_locked = 1'b1;
        if (err) err_seen++;
        en  = e;
        din = d;
        clr = c;
        if (e) vcount++;
        model_step(e, d, c);
        x.locked  = (m_state == 2);
        x.err     = m_err;
        x.err_cnt = m_errcnt;
        exp_q.push_back(x);
    endtask

    task automatic prbs(input int n);
        bit b;
        repeat (n) begin
            gen_next(b);
            cycle(1'b1, b, 1'b0);
        end
    endtask

    task automatic inject();
        bit b;
        gen_next(b);
        cycle(1'b1, ~b, 1'b0);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        din   = 1'b0;
        #1;
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("mon_locked", int'(locked), int'(e.locked));
                check("mon_err", int'(err), int'(e.err));
                check("mon_err_cnt", int'(err_cnt), e.err_cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [25:0] s;
        bit b;
        int inj_rate;

        m_reset();
        #12;
        check("por_locked", int'(locked), 0);
        check("por_err", int'(err), 0);
        check("por_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean stream from seed 1: lock after 26 + LOCK_CNT bits.
        gen_seed(26'd1);
        obs_clear();
        prbs(70);
        cycle(1'b0, 1'b0, 1'b0);
        check("clean_lock_latency", lock_at, 58);
        check("clean_err_pulses", err_seen, 0);
        sample();
        check("clean_err_cnt", int'(err_cnt), 0);

        // Single line error: one pulse, lock held.
        obs_clear();
        inject();
        prbs(10);
        cycle(1'b0, 1'b0, 1'b0);
        check("single_err_pulses", err_seen, 1);
        sample();
        check("single_err_cnt", int'(err_cnt), 1);
        check("single_locked", int'(locked), 1);

        // Eight errors in one window force loss, then relock on a clean stream.
        do_reset("rst_a");
        s = 26'($urandom);
        if (s == 26'd0) s = 26'd1;
        gen_seed(s);
        obs_clear();
        prbs(70);
        obs_clear();
        for (int i = 0; i < LOSS_ERRS; i++) begin
            inject();
            if (i < LOSS_ERRS - 1) prbs(2);
        end
        vcount  = 0;
        lock_at = -1;
        prbs(70);
        cycle(1'b0, 1'b0, 1'b0);
        check("loss_err_pulses", err_seen, 8);
        check("relock_latency", lock_at, 58);
        sample();
        check("loss_err_cnt", int'(err_cnt), 8);

        // All-zero stream never locks.
        do_reset("rst_b");
        obs_clear();
        repeat (200) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("zero_never_locks", int'(ever_locked), 0);
        sample();
        check("zero_err_cnt", int'(err_cnt), 0);

        // en low every third cycle: latency counted in valid bits only.
        do_reset("rst_c");
        gen_seed(26'd1);
        obs_clear();
        for (int c = 0; c < 100; c++) begin
            if (c % 3 == 2) cycle(1'b0, 1'($urandom), 1'b0);
            else begin
                gen_next(b);
                cycle(1'b1, b, 1'b0);
            end
        end
        cycle(1'b0, 1'b0, 1'b0);
        check("gated_lock_latency", lock_at, 58);

        // clr coincident with an error, then async reset while LOCKED.
        do_reset("rst_d");
        s = 26'($urandom);
        if (s == 26'd0) s = 26'd3;
        gen_seed(s);
        obs_clear();
        prbs(70);
        repeat (5) begin
            inject();
            prbs(3);
        end
        cycle(1'b0, 1'b0, 1'b0);
        sample();
        check("pre_clr_err_cnt", int'(err_cnt), 5);
        gen_next(b);
        cycle(1'b1, ~b, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        sample();
        check("clr_with_err_cnt", int'(err_cnt), 1);
        check("clr_locked", int'(locked), 1);
        prbs(3);
        do_reset("rst_mid_locked");

        // Randomised traffic with sparse errors, an error burst and random clr.
        s = 26'($urandom);
        if (s == 26'd0) s = 26'd5;
        gen_seed(s);
        for (int c = 0; c < 4000; c++) begin
            inj_rate = (c >= 1500 && c < 1600) ? 30 : 1;
            if ($urandom_range(0, 9) == 0) begin
                cycle(1'b0, 1'($urandom), ($urandom_range(0, 199) == 0));
            end else begin
                gen_next(b);
                if ($urandom_range(0, 99) < inj_rate) b = ~b;
                cycle(1'b1, b, ($urandom_range(0, 199) == 0));
            end
        end
        cycle(1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
